// File: rtl/onchip_mem_pkg.sv
// Shared constants and helpers for the dual-port on-chip memory.
// Lane math and the cross-port write merge live here.
package onchip_mem_pkg;

  localparam int RL_MIN = 1;
  localparam int RL_MAX = 2;

  typedef enum logic [1:0] {
    RL_RAW = 2'd1,
    RL_REG = 2'd2
  } read_latency_e;

  function automatic int lane_count(input int data_w);
    return data_w / 8;
  endfunction

  function automatic logic rl_is_legal(input int rl);
    return (rl >= RL_MIN) && (rl <= RL_MAX);
  endfunction

  // On a same-address collision s1 owns every lane it enables;
  // s2 keeps only the lanes s1 left alone.
  function automatic logic s2_lane_we(
    input logic collide,
    input logic s1_be,
    input logic s2_be
  );
    return s2_be & ~(collide & s1_be);
  endfunction

endpackage

// File: rtl/onchip_memory_dp_bank.sv
// Raw true-dual-port byte-enabled storage, old-data read-during-write.
// No reset: contents survive reset_n and start undefined.
module onchip_ram_bank
  import onchip_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 51200,
  parameter int ADDR_W = 16
) (
  input  logic                clk,
  input  logic                en,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic                a_we,
  input  logic [DATA_W/8-1:0] a_be,
  input  logic [DATA_W-1:0]   a_wdata,
  input  logic                a_re,
  output logic [DATA_W-1:0]   a_rdata,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic                b_we,
  input  logic [DATA_W/8-1:0] b_be,
  input  logic [DATA_W-1:0]   b_wdata,
  input  logic                b_re,
  output logic [DATA_W-1:0]   b_rdata
);

  localparam int LANES = lane_count(DATA_W);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] a_rdata_q;
  logic [DATA_W-1:0] a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q;
  logic [DATA_W-1:0] b_rdata_d;

  always_comb begin
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    if (en && a_re) begin
      a_rdata_d = mem_q[a_addr];
    end
    if (en && b_re) begin
      b_rdata_d = mem_q[b_addr];
    end
  end

  always_ff @(posedge clk) begin
    a_rdata_q <= a_rdata_d;
    b_rdata_q <= b_rdata_d;
  end

  // Port a is applied last so it wins any lane both ports enable.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < LANES; i++) begin
        if (b_we && b_be[i]) begin
          mem_q[b_addr][8*i +: 8] <= b_wdata[8*i +: 8];
        end
      end
      for (int i = 0; i < LANES; i++) begin
        if (a_we && a_be[i]) begin
          mem_q[a_addr][8*i +: 8] <= a_wdata[8*i +: 8];
        end
      end
    end
  end

  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;

endmodule

// File: rtl/onchip_memory_dp.sv
// Dual-port Avalon-MM on-chip RAM: range checks, s1-over-s2 merge,
// per-port readdatavalid pipelines and clken freeze around the bank.
module onchip_memory_dp
  import onchip_mem_pkg::*;
#(
  parameter int    DATA_W       = 32,
  parameter int    DEPTH        = 51200,
  parameter int    ADDR_W       = 16,
  parameter int    READ_LATENCY = 1,
  parameter string INIT_FILE    = "onchip_memory2.hex"
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clken,
  input  logic [ADDR_W-1:0]   s1_address,
  input  logic                s1_chipselect,
  input  logic                s1_read,
  input  logic                s1_write,
  input  logic [DATA_W/8-1:0] s1_byteenable,
  input  logic [DATA_W-1:0]   s1_writedata,
  output logic [DATA_W-1:0]   s1_readdata,
  output logic                s1_readdatavalid,
  input  logic [ADDR_W-1:0]   s2_address,
  input  logic                s2_chipselect,
  input  logic                s2_read,
  input  logic                s2_write,
  input  logic [DATA_W/8-1:0] s2_byteenable,
  input  logic [DATA_W-1:0]   s2_writedata,
  output logic [DATA_W-1:0]   s2_readdata,
  output logic                s2_readdatavalid,
  output logic                oor_error
);

  localparam int LANES = lane_count(DATA_W);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  if (INIT_FILE != "") begin : g_init_file
    // Preload is applied by the vendor RAM flow, not by this RTL.
  end

  logic             s1_acc;
  logic             s1_oor;
  logic             s1_we;
  logic             s1_re;
  logic             s1_bank_re;
  logic             s2_acc;
  logic             s2_oor;
  logic             s2_we;
  logic             s2_re;
  logic             s2_bank_re;
  logic             collide;
  logic [LANES-1:0] s2_be_eff;

  always_comb begin
    s1_acc = clken & s1_chipselect & (s1_read | s1_write);
    s2_acc = clken & s2_chipselect & (s2_read | s2_write);
    s1_oor = {1'b0, s1_address} >= DEPTH_C;
    s2_oor = {1'b0, s2_address} >= DEPTH_C;
    s1_we  = s1_acc & s1_write & ~s1_oor;
    s2_we  = s2_acc & s2_write & ~s2_oor;
    s1_re  = s1_acc & s1_read & reset_n;
    s2_re  = s2_acc & s2_read & reset_n;
    s1_bank_re = s1_re & ~s1_oor;
    s2_bank_re = s2_re & ~s2_oor;
    collide = s1_we & s2_we & (s1_address == s2_address);
    for (int i = 0; i < LANES; i++) begin
      s2_be_eff[i] = s2_lane_we(collide, s1_byteenable[i],
                                s2_byteenable[i]);
    end
  end

  logic [DATA_W-1:0] s1_bank_q;
  logic [DATA_W-1:0] s2_bank_q;

  onchip_ram_bank #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_bank (
    .clk     (clk),
    .en      (clken),
    .a_addr  (s1_address),
    .a_we    (s1_we),
    .a_be    (s1_byteenable),
    .a_wdata (s1_writedata),
    .a_re    (s1_bank_re),
    .a_rdata (s1_bank_q),
    .b_addr  (s2_address),
    .b_we    (s2_we),
    .b_be    (s2_be_eff),
    .b_wdata (s2_writedata),
    .b_re    (s2_bank_re),
    .b_rdata (s2_bank_q)
  );

  // Stage 1: valid plus a flag saying the bank word is real data
  // (cleared for out-of-range reads and by reset).
  logic s1_v1_q;
  logic s1_v1_d;
  logic s1_ok1_q;
  logic s1_ok1_d;
  logic s2_v1_q;
  logic s2_v1_d;
  logic s2_ok1_q;
  logic s2_ok1_d;
  logic oor_q;
  logic oor_d;

  always_comb begin
    s1_v1_d  = s1_v1_q;
    s1_ok1_d = s1_ok1_q;
    s2_v1_d  = s2_v1_q;
    s2_ok1_d = s2_ok1_q;
    oor_d    = oor_q;
    if (clken) begin
      s1_v1_d = s1_re;
      s2_v1_d = s2_re;
      oor_d   = (s1_acc & s1_oor) | (s2_acc & s2_oor);
      if (s1_re) begin
        s1_ok1_d = ~s1_oor;
      end
      if (s2_re) begin
        s2_ok1_d = ~s2_oor;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_v1_q  <= 1'b0;
      s1_ok1_q <= 1'b0;
      s2_v1_q  <= 1'b0;
      s2_ok1_q <= 1'b0;
      oor_q    <= 1'b0;
    end else begin
      s1_v1_q  <= s1_v1_d;
      s1_ok1_q <= s1_ok1_d;
      s2_v1_q  <= s2_v1_d;
      s2_ok1_q <= s2_ok1_d;
      oor_q    <= oor_d;
    end
  end

  logic [DATA_W-1:0] s1_rd1;
  logic [DATA_W-1:0] s2_rd1;

  assign s1_rd1 = s1_ok1_q ? s1_bank_q : '0;
  assign s2_rd1 = s2_ok1_q ? s2_bank_q : '0;
  assign oor_error = oor_q;

  if (READ_LATENCY >= RL_MAX) begin : g_rl2
    logic              s1_v2_q;
    logic              s1_v2_d;
    logic              s2_v2_q;
    logic              s2_v2_d;
    logic [DATA_W-1:0] s1_rd2_q;
    logic [DATA_W-1:0] s1_rd2_d;
    logic [DATA_W-1:0] s2_rd2_q;
    logic [DATA_W-1:0] s2_rd2_d;

    always_comb begin
      s1_v2_d  = s1_v2_q;
      s2_v2_d  = s2_v2_q;
      s1_rd2_d = s1_rd2_q;
      s2_rd2_d = s2_rd2_q;
      if (clken) begin
        s1_v2_d = s1_v1_q;
        s2_v2_d = s2_v1_q;
        if (s1_v1_q) begin
          s1_rd2_d = s1_rd1;
        end
        if (s2_v1_q) begin
          s2_rd2_d = s2_rd1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        s1_v2_q  <= 1'b0;
        s2_v2_q  <= 1'b0;
        s1_rd2_q <= '0;
        s2_rd2_q <= '0;
      end else begin
        s1_v2_q  <= s1_v2_d;
        s2_v2_q  <= s2_v2_d;
        s1_rd2_q <= s1_rd2_d;
        s2_rd2_q <= s2_rd2_d;
      end
    end

    assign s1_readdatavalid = s1_v2_q;
    assign s2_readdatavalid = s2_v2_q;
    assign s1_readdata      = s1_rd2_q;
    assign s2_readdata      = s2_rd2_q;
  end else begin : g_rl1
    assign s1_readdatavalid = s1_v1_q;
    assign s2_readdatavalid = s2_v1_q;
    assign s1_readdata      = s1_rd1;
    assign s2_readdata      = s2_rd1;
  end

endmodule
